// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32 control FSM with memory-ack timeout trap
// Optional: define MCC_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of retiring them as NOPs.
module multicycle_control #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       imem_ack,
   input  logic       dmem_ack,
   output logic       imem_req,
   output logic       dmem_req,
   output logic       dmem_we,
   output logic       ir_write,
   output logic       pc_write,
   output logic       branch,
   output logic       memRead,
   output logic       memtoReg,
   output logic       memWrite,
   output logic       ALUSrc,
   output logic       regWrite,
   output logic       jal,
   output logic       jalr,
   output logic       lui,
   output logic       auipc,
   output logic [1:0] ALUOp,
   output logic [2:0] state,
   output logic       err
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_TRAP   = 3'd5;

   localparam logic [3:0] C_ILLEGAL = 4'd0;
   localparam logic [3:0] C_LOAD    = 4'd1;
   localparam logic [3:0] C_OPIMM   = 4'd2;
   localparam logic [3:0] C_STORE   = 4'd3;
   localparam logic [3:0] C_OP      = 4'd4;
   localparam logic [3:0] C_BRANCH  = 4'd5;
   localparam logic [3:0] C_JALR    = 4'd6;
   localparam logic [3:0] C_JAL     = 4'd7;
   localparam logic [3:0] C_LUI     = 4'd8;
   localparam logic [3:0] C_AUIPC   = 4'd9;

   logic [3:0]       cls;
   logic [3:0]       dec_cls;
   logic [2:0]       state_nx;
   logic [CNT_W-1:0] wait_cnt;
   logic             wait_last;
   logic             ctl_en;

   always_comb begin
      dec_cls = C_ILLEGAL;
      case (opcode)
         7'b0000011: dec_cls = C_LOAD;
         7'b0010011: dec_cls = C_OPIMM;
         7'b0100011: dec_cls = C_STORE;
         7'b0110011: dec_cls = C_OP;
         7'b1100011: dec_cls = C_BRANCH;
         7'b1100111: dec_cls = C_JALR;
         7'b1101111: dec_cls = C_JAL;
         7'b0110111: dec_cls = C_LUI;
         7'b0010111: dec_cls = C_AUIPC;
         default:    dec_cls = C_ILLEGAL;
      endcase
   end

   // The cycle whose missing ack would bring the wait count to TIMEOUT_CYCLES.
   assign wait_last = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:  if (imem_ack) state_nx = S_DECODE;
                   else if (wait_last) state_nx = S_TRAP;
         S_DECODE: state_nx = S_EXEC;
         S_EXEC: begin
            case (cls)
               C_LOAD, C_STORE: state_nx = S_MEM;
               C_BRANCH:        state_nx = S_FETCH;
`ifdef MCC_ILLEGAL_TRAP_EN
               C_ILLEGAL:       state_nx = S_TRAP;
`else
               C_ILLEGAL:       state_nx = S_FETCH;
`endif
               default:         state_nx = S_WB;
            endcase
         end
         S_MEM:    if (dmem_ack) state_nx = (cls == C_STORE) ? S_FETCH : S_WB;
                   else if (wait_last) state_nx = S_TRAP;
         S_WB:     state_nx = S_FETCH;
         S_TRAP:   state_nx = S_TRAP;
         default:  state_nx = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         cls      <= C_ILLEGAL;
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == S_DECODE) cls <= dec_cls;
         if (state_nx != state) wait_cnt <= '0;
         else if (state == S_FETCH || state == S_MEM) wait_cnt <= wait_cnt + CNT_W'(1);
         if (state_nx == S_TRAP) err <= 1'b1;
      end
   end

   assign ctl_en = !rst && (state == S_EXEC || state == S_MEM || state == S_WB);

   always_comb begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      branch   = 1'b0;
      memRead  = 1'b0;
      memtoReg = 1'b0;
      memWrite = 1'b0;
      ALUSrc   = 1'b0;
      regWrite = 1'b0;
      jal      = 1'b0;
      jalr     = 1'b0;
      lui      = 1'b0;
      auipc    = 1'b0;
      ALUOp    = 2'b00;
      if (ctl_en) begin
         // regWrite is confined to WB so each instruction writes the register file once.
         case (cls)
            C_LOAD:   begin memRead = 1'b1; memtoReg = 1'b1; ALUSrc = 1'b1; regWrite = (state == S_WB); end
            C_STORE:  begin memWrite = 1'b1; ALUSrc = 1'b1; end
            C_OP:     begin ALUOp = 2'b10; regWrite = (state == S_WB); end
            C_OPIMM:  begin ALUOp = 2'b11; ALUSrc = 1'b1; regWrite = (state == S_WB); end
            C_BRANCH: begin branch = 1'b1; ALUOp = 2'b01; end
            C_JAL:    begin jal = 1'b1; regWrite = (state == S_WB); end
            C_JALR:   begin jalr = 1'b1; ALUSrc = 1'b1; regWrite = (state == S_WB); end
            C_LUI:    begin lui = 1'b1; ALUSrc = 1'b1; regWrite = (state == S_WB); end
            C_AUIPC:  begin auipc = 1'b1; ALUSrc = 1'b1; regWrite = (state == S_WB); end
            default:  ;
         endcase
      end
      if (!rst) begin
         case (state)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ack;
            end
            S_EXEC: begin
`ifdef MCC_ILLEGAL_TRAP_EN
               pc_write = (cls == C_BRANCH);
`else
               pc_write = (cls == C_BRANCH) || (cls == C_ILLEGAL);
`endif
            end
            S_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = (cls == C_STORE);
               pc_write = (cls == C_STORE) && dmem_ack;
            end
            S_WB:    pc_write = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
// Expected values follow MCC_ILLEGAL_TRAP_EN when it is defined for the build.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       imem_ack, dmem_ack;
   logic       imem_req, dmem_req, dmem_we, ir_write, pc_write;
   logic       branch, memRead, memtoReg, memWrite, ALUSrc, regWrite;
   logic       jal, jalr, lui, auipc;
   logic [1:0] ALUOp;
   logic [2:0] state;
   logic       err;

   int checks = 0;
   int failures = 0;
   int req_cnt;
   int pcw_cnt;

   multicycle_control dut (
      .clk(clk), .rst(rst), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write),
      .pc_write(pc_write), .branch(branch), .memRead(memRead), .memtoReg(memtoReg),
      .memWrite(memWrite), .ALUSrc(ALUSrc), .regWrite(regWrite), .jal(jal), .jalr(jalr),
      .lui(lui), .auipc(auipc), .ALUOp(ALUOp), .state(state), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Fetch with ack, pass through DECODE, end at the start of EXEC.
   task automatic fetch_to_exec(input logic [6:0] op);
      opcode = op;
      imem_ack = 1'b1;
      #1;
      chk("fetch_ir_write", 8'(ir_write), 8'd1);
      tick();
      imem_ack = 1'b0;
      #1;
      chk("decode_state", 8'(state), 8'd1);
      tick();
   endtask

   initial begin
      rst = 1'b1; opcode = 7'd0; imem_ack = 1'b0; dmem_ack = 1'b0;
      tick();
      #1;
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_err", 8'(err), 8'd0);
      chk("rst_imem_req", 8'(imem_req), 8'd0);
      chk("rst_pc_write", 8'(pc_write), 8'd0);
      tick();

      // R-type: cycle 1 idle, ack in cycle 2, DECODE 3, EXEC 4, WB 5, FETCH 6
      rst = 1'b0; dmem_ack = 1'b1;
      #1;
      chk("c1_imem_req", 8'(imem_req), 8'd1);
      chk("c1_dmem_req", 8'(dmem_req), 8'd0);
      chk("c1_ir_write", 8'(ir_write), 8'd0);
      tick();
      dmem_ack = 1'b0;
      chk("c2_state", 8'(state), 8'd0);
      fetch_to_exec(7'b0110011);
      opcode = 7'b1111111;
      #1;
      chk("op_exec_state", 8'(state), 8'd2);
      chk("op_exec_aluop", 8'(ALUOp), 8'd2);
      chk("op_exec_pcw", 8'(pc_write), 8'd0);
      tick();
      #1;
      chk("op_wb_state", 8'(state), 8'd4);
      chk("op_wb_regwrite", 8'(regWrite), 8'd1);
      chk("op_wb_aluop", 8'(ALUOp), 8'd2);
      chk("op_wb_pcw", 8'(pc_write), 8'd1);
      tick();
      chk("op_c6_state", 8'(state), 8'd0);

      // LW with dmem_ack in the 4th MEM cycle
      fetch_to_exec(7'b0000011);
      #1;
      chk("lw_exec_memread", 8'(memRead), 8'd1);
      chk("lw_exec_alusrc", 8'(ALUSrc), 8'd1);
      tick();
      req_cnt = 0; pcw_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         dmem_ack = (i == 3);
         #1;
         if (dmem_req) req_cnt++;
         if (pc_write) pcw_cnt++;
         if (i == 0) begin
            chk("lw_mem_we", 8'(dmem_we), 8'd0);
            chk("lw_mem_memread", 8'(memRead), 8'd1);
         end
         tick();
      end
      dmem_ack = 1'b0;
      chk("lw_req_cycles", 8'(req_cnt), 8'd4);
      chk("lw_mem_pcw", 8'(pcw_cnt), 8'd0);
      #1;
      chk("lw_wb_state", 8'(state), 8'd4);
      chk("lw_wb_memtoreg", 8'(memtoReg), 8'd1);
      chk("lw_wb_regwrite", 8'(regWrite), 8'd1);
      chk("lw_wb_pcw", 8'(pc_write), 8'd1);
      chk("lw_wb_dmem_req", 8'(dmem_req), 8'd0);
      tick();

      // SW: ack on second MEM cycle retires straight to FETCH
      fetch_to_exec(7'b0100011);
      #1;
      chk("sw_exec_memwrite", 8'(memWrite), 8'd1);
      tick();
      #1;
      chk("sw_mem_state", 8'(state), 8'd3);
      chk("sw_mem_we", 8'(dmem_we), 8'd1);
      chk("sw_mem_regwrite", 8'(regWrite), 8'd0);
      chk("sw_mem_pcw_wait", 8'(pc_write), 8'd0);
      tick();
      dmem_ack = 1'b1;
      #1;
      chk("sw_ack_pcw", 8'(pc_write), 8'd1);
      tick();
      dmem_ack = 1'b0;
      chk("sw_after_state", 8'(state), 8'd0);

      // BRANCH retires from EXEC
      fetch_to_exec(7'b1100011);
      #1;
      chk("br_branch", 8'(branch), 8'd1);
      chk("br_aluop", 8'(ALUOp), 8'd1);
      chk("br_pcw", 8'(pc_write), 8'd1);
      tick();
      chk("br_after_state", 8'(state), 8'd0);

      // JAL goes through WB
      fetch_to_exec(7'b1101111);
      #1;
      chk("jal_exec_jal", 8'(jal), 8'd1);
      chk("jal_exec_regwrite", 8'(regWrite), 8'd0);
      tick();
      chk("jal_wb_state", 8'(state), 8'd4);
      chk("jal_wb_regwrite", 8'(regWrite), 8'd1);
      tick();

      // Fetch timeout: 16 cycles without ack traps, trap holds with ack present
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         #1;
         chk("to_wait_state", 8'(state), 8'd0);
         tick();
      end
      imem_ack = 1'b1;
      #1;
      chk("to_trap_state", 8'(state), 8'd5);
      chk("to_trap_err", 8'(err), 8'd1);
      chk("to_trap_imem_req", 8'(imem_req), 8'd0);
      chk("to_trap_ir_write", 8'(ir_write), 8'd0);
      tick(); tick();
      chk("to_trap_hold", 8'(state), 8'd5);
      chk("to_trap_err_hold", 8'(err), 8'd1);

      // Ack on the 16th cycle wins over the timeout
      imem_ack = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
      opcode = 7'b0010011;
      for (int i = 0; i < 15; i++) tick();
      imem_ack = 1'b1;
      #1;
      chk("to16_ir_write", 8'(ir_write), 8'd1);
      tick();
      imem_ack = 1'b0;
      chk("to16_state", 8'(state), 8'd1);
      chk("to16_err", 8'(err), 8'd0);
      tick();
      chk("opimm_aluop", 8'(ALUOp), 8'd3);
      tick(); tick();

      // Illegal opcode
      fetch_to_exec(7'b1111111);
      #1;
`ifdef MCC_ILLEGAL_TRAP_EN
      chk("ill_exec_pcw", 8'(pc_write), 8'd0);
      tick();
      chk("ill_state", 8'(state), 8'd5);
      chk("ill_err", 8'(err), 8'd1);
`else
      chk("ill_exec_pcw", 8'(pc_write), 8'd1);
      chk("ill_exec_ctl", 8'({ALUOp, regWrite, ALUSrc, memRead, memWrite, branch}), 8'd0);
      tick();
      chk("ill_state", 8'(state), 8'd0);
      chk("ill_err", 8'(err), 8'd0);
`endif

      // Reset during MEM aborts the load without a pc_write
      rst = 1'b1; tick(); rst = 1'b0;
      fetch_to_exec(7'b0000011);
      tick();
      chk("abort_mem_state", 8'(state), 8'd3);
      rst = 1'b1; dmem_ack = 1'b1;
      #1;
      chk("abort_rst_pcw", 8'(pc_write), 8'd0);
      chk("abort_rst_dmem_req", 8'(dmem_req), 8'd0);
      tick();
      rst = 1'b0; dmem_ack = 1'b0;
      #1;
      chk("abort_state", 8'(state), 8'd0);
      chk("abort_pcw", 8'(pc_write), 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum wait cycles for a memory acknowledge in FETCH or MEM before trapping.
REQ-002 Parameter CNT_W, default $clog2(TIMEOUT_CYCLES+1): width of the wait counter.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  instr[6:0] from the instruction register
- imem_ack  in  1  instruction memory acknowledge
- dmem_ack  in  1  data memory acknowledge
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data access request
- dmem_we  out  1  data write enable, store only
- ir_write  out  1  instruction register load strobe
- pc_write  out  1  PC update strobe
- branch, memRead, memtoReg, memWrite, ALUSrc, regWrite, jal, jalr, lui, auipc  out  1 each  datapath controls
- ALUOp  out  2  00 add, 01 branch compare, 10 R-type, 11 I-type
- state  out  3  current FSM state
- err  out  1  sticky trap flag

Function
REQ-004 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to FETCH on the next cycle.
REQ-005 FETCH: imem_req=1 every cycle; when imem_ack=1 at a clock edge, ir_write=1 in that cycle and next state is DECODE.
REQ-006 DECODE (1 cycle): opcode SHALL be classified into LOAD 0000011, OPIMM 0010011, STORE 0100011, OP 0110011, BRANCH 1100011, JALR 1100111, JAL 1101111, LUI 0110111, AUIPC 0010111, or ILLEGAL; the class SHALL be registered; next state is EXEC; later opcode changes SHALL be ignored.
REQ-007 Datapath controls SHALL be driven from the registered class in EXEC, MEM and WB, and SHALL be 0 in FETCH, DECODE and TRAP; the per-class values match the single-cycle decoder, with ALUOp 00 and ALUSrc 1 for LUI/AUIPC.
REQ-008 EXEC transitions: LOAD/STORE -> MEM; BRANCH -> FETCH with pc_write=1; OP/OPIMM/JAL/JALR/LUI/AUIPC -> WB.
REQ-009 MEM: dmem_req=1, dmem_we=1 for STORE only; on dmem_ack, LOAD -> WB, and STORE -> FETCH with pc_write=1.
REQ-010 WB (1 cycle): regWrite=1, pc_write=1, next state FETCH.
REQ-011 pc_write SHALL pulse exactly once per retired instruction; ir_write exactly once per fetch.
REQ-012 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle without ack; when it equals TIMEOUT_CYCLES without ack, next state SHALL be TRAP.
REQ-013 An ack arriving on the same edge as the timeout SHALL win and proceed normally.
REQ-014 imem_ack outside FETCH and dmem_ack outside MEM SHALL be ignored.
REQ-015 TRAP SHALL hold err=1 with all requests and strobes 0 until rst.
REQ-016 Combinational outputs SHALL depend only on the registered state and class; there is no opcode-to-output combinational path.

Reset
REQ-017 On rst=1 at an edge: state=FETCH, class=ILLEGAL, wait counter=0, err=0; all strobes and controls are 0 during the reset cycle.
REQ-018 rst SHALL abort any in-flight access mid-operation; no pc_write is issued for the aborted instruction.

Configuration
REQ-019 Macro MCC_ILLEGAL_TRAP_EN: when defined, an ILLEGAL class in EXEC SHALL go to TRAP; when undefined, ILLEGAL SHALL execute as a NOP (EXEC -> FETCH, pc_write=1, all controls 0).

Verification
REQ-020 Opcode 0110011, imem_ack at cycle 2 -> ir_write in cycle 2, then DECODE, EXEC, WB with regWrite=1, ALUOp=10, pc_write=1; back in FETCH at cycle 6.
REQ-021 LW (0000011), dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, memRead=1, dmem_we=0, then WB with memtoReg=1.
REQ-022 SW (0100011) -> MEM with dmem_we=1, memWrite=1, regWrite=0; pc_write on the ack cycle; no WB.
REQ-023 No imem_ack for 16 cycles -> TRAP, err=1 and held; ack on the 16th cycle instead -> DECODE, err=0.
REQ-024 Opcode 1111111 -> TRAP with macro defined, NOP retire without it; rst asserted in MEM -> FETCH next cycle, pc_write never asserted.
